// File: rtl/bf_stage16.sv
// Radix-2 SDF butterfly for stage 1 of the 32-point FFT: 16-deep delay line,
// g = b + a in FIRST, h*WN in SECOND, all results registered (1 clk latency).
module bf_stage16 #(
  parameter int DW      = 16,
  parameter int TW      = 8,
  parameter int TW_FRAC = 6,
  parameter int DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           state,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] a_r,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [TW-1:0] wn_r,
  input  logic signed [TW-1:0] wn_i,
  output logic                 valid_o,
  output logic signed [DW-1:0] data_out_r,
  output logic signed [DW-1:0] data_out_i
);

  localparam int PW = DW + TW;
  localparam int MW = DW + TW + 1;
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [MW-1:0] RND  = MW'(1 << (TW_FRAC - 1));

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_FIRST  = 2'b01,
    PH_SECOND = 2'b10,
    PH_WAIT   = 2'b11
  } phase_e;

  function automatic logic signed [DW-1:0] addsub_sat(input logic signed [DW-1:0] x,
                                                       input logic signed [DW-1:0] y,
                                                       input logic             sub);
    logic signed [DW:0] s;
    s = sub ? ({x[DW-1], x} - {y[DW-1], y}) : ({x[DW-1], x} + {y[DW-1], y});
    if (s[DW] != s[DW-1]) return s[DW] ? SMIN : SMAX;
    return s[DW-1:0];
  endfunction

  // Round half up at the twiddle's binary point, then clamp to DW bits.
  function automatic logic signed [DW-1:0] rnd_sat(input logic signed [MW-1:0] p);
    logic signed [MW-1:0] r;
    r = (p + RND) >>> TW_FRAC;
    if (r[MW-1:DW-1] == '0 || r[MW-1:DW-1] == '1) return r[DW-1:0];
    return r[MW-1] ? SMIN : SMAX;
  endfunction

  phase_e                phase;
  logic signed [DW-1:0]  sr_r_q [DEPTH];
  logic signed [DW-1:0]  sr_i_q [DEPTH];
  logic signed [DW-1:0]  b_r, b_i;
  logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
  logic signed [MW-1:0]  m_re, m_im;
  logic                  shift_en;
  logic signed [DW-1:0]  sr_in_r, sr_in_i;
  logic signed [DW-1:0]  dout_r_d, dout_i_d, dout_r_q, dout_i_q;
  logic                  valid_d, valid_q;

  assign phase = phase_e'(state);

  always_comb begin
    b_r      = sr_r_q[DEPTH-1];
    b_i      = sr_i_q[DEPTH-1];
    p_rr     = PW'(b_r) * PW'(wn_r);
    p_ii     = PW'(b_i) * PW'(wn_i);
    p_ri     = PW'(b_r) * PW'(wn_i);
    p_ir     = PW'(b_i) * PW'(wn_r);
    m_re     = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
    m_im     = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    shift_en = (phase != PH_IDLE);
    sr_in_r  = a_r;
    sr_in_i  = a_i;
    dout_r_d = '0;
    dout_i_d = '0;
    case (phase)
      PH_FIRST: begin
        dout_r_d = addsub_sat(b_r, a_r, 1'b0);
        dout_i_d = addsub_sat(b_i, a_i, 1'b0);
        sr_in_r  = addsub_sat(b_r, a_r, 1'b1);
        sr_in_i  = addsub_sat(b_i, a_i, 1'b1);
      end
      PH_SECOND: begin
        dout_r_d = rnd_sat(m_re);
        dout_i_d = rnd_sat(m_im);
      end
      default: ;
    endcase
    valid_d = valid_i & ((phase == PH_FIRST) | (phase == PH_SECOND));
  end

  // Register stage: delay line and output result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_r_q[i] <= '0;
        sr_i_q[i] <= '0;
      end
      dout_r_q <= '0;
      dout_i_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (shift_en) begin
        sr_r_q[0] <= sr_in_r;
        sr_i_q[0] <= sr_in_i;
        for (int i = 1; i < DEPTH; i++) begin
          sr_r_q[i] <= sr_r_q[i-1];
          sr_i_q[i] <= sr_i_q[i-1];
        end
      end
      dout_r_q <= dout_r_d;
      dout_i_q <= dout_i_d;
      valid_q  <= valid_d;
    end
  end

  assign data_out_r = dout_r_q;
  assign data_out_i = dout_i_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_bf_stage16.sv
// Scoreboard bench for bf_stage16: frame-level reference model pushes expected
// outputs; a monitor pops and compares whenever valid_o is high.
module tb_bf_stage16;

  localparam logic [1:0] S_IDLE = 2'b00, S_FIRST = 2'b01, S_SECOND = 2'b10, S_WAIT = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         state;
  logic               valid_i;
  logic signed [15:0] a_r, a_i;
  logic signed [7:0]  wn_r, wn_i;
  logic               valid_o;
  logic signed [15:0] data_out_r, data_out_i;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int exp_r[$];
  int exp_i[$];
  int fxr[32], fxi[32], fwr[16], fwi[16];

  bf_stage16 dut (
    .clk(clk), .rst(rst), .state(state), .valid_i(valid_i),
    .a_r(a_r), .a_i(a_i), .wn_r(wn_r), .wn_i(wn_i),
    .valid_o(valid_o), .data_out_r(data_out_r), .data_out_i(data_out_i)
  );

  always #5 clk = ~clk;

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Q2.6 product back to integer: floor((p + 0.5*64) / 64), clamped.
  function automatic int rsat(input longint p);
    return sat16((p + 32) >>> 6);
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic drive(input logic [1:0] st, input logic v,
                       input int ar, input int ai, input int wr, input int wi);
    @(negedge clk);
    state   = st;
    valid_i = v;
    a_r     = 16'(ar);
    a_i     = 16'(ai);
    wn_r    = 8'(wr);
    wn_i    = 8'(wi);
  endtask

  task automatic set_frame(input bit rand_first, input bit rand_second);
    for (int k = 0; k < 32; k++) begin
      fxr[k] = ((k < 16) ? rand_first : rand_second) ? rnd16() : 0;
      fxi[k] = ((k < 16) ? rand_first : rand_second) ? rnd16() : 0;
    end
    for (int k = 0; k < 16; k++) begin
      fwr[k] = rnd8();
      fwi[k] = rnd8();
    end
  endtask

  // One frame: x[0..15] in WAITING, x[16..31] in FIRST, twiddles in SECOND.
  task automatic run_frame(input bit skip_wait, input int n_first);
    int hr[16], hi[16];
    if (!skip_wait)
      for (int k = 0; k < 16; k++) drive(S_WAIT, 1'b0, fxr[k], fxi[k], rnd8(), rnd8());
    for (int k = 0; k < n_first; k++) begin
      hr[k] = sat16(longint'(fxr[k]) - fxr[k+16]);
      hi[k] = sat16(longint'(fxi[k]) - fxi[k+16]);
      exp_r.push_back(sat16(longint'(fxr[k]) + fxr[k+16]));
      exp_i.push_back(sat16(longint'(fxi[k]) + fxi[k+16]));
      drive(S_FIRST, 1'b1, fxr[k+16], fxi[k+16], rnd8(), rnd8());
    end
    if (n_first < 16) return;
    for (int k = 0; k < 16; k++) begin
      exp_r.push_back(rsat(longint'(hr[k]) * fwr[k] - longint'(hi[k]) * fwi[k]));
      exp_i.push_back(rsat(longint'(hr[k]) * fwi[k] + longint'(hi[k]) * fwr[k]));
      drive(S_SECOND, 1'b1, rnd16(), rnd16(), fwr[k], fwi[k]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(S_IDLE, 1'b0, rnd16(), rnd16(), rnd8(), rnd8());
  endtask

  // Monitor
  initial begin
    int er, ei;
    forever begin
      @(posedge clk);
      #2;
      checks++;
      if (valid_o === 1'b1) begin
        vcnt++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid got=(%0d,%0d) expected no output", data_out_r, data_out_i);
        end else begin
          er = exp_r.pop_front();
          ei = exp_i.pop_front();
          if (int'(data_out_r) != er || int'(data_out_i) != ei) begin
            errors++;
            $display("FAIL out_data t=%0t got=(%0d,%0d) expected=(%0d,%0d)",
                     $time, data_out_r, data_out_i, er, ei);
          end
        end
      end else if (valid_o !== 1'b0 || data_out_r !== 16'sd0 || data_out_i !== 16'sd0) begin
        errors++;
        $display("FAIL idle_out t=%0t got valid=%b (%0d,%0d) expected valid=0 (0,0)",
                 $time, valid_o, data_out_r, data_out_i);
      end
    end
  end

  initial begin
    int v0;
    rst = 1'b0; state = S_IDLE; valid_i = 1'b0;
    a_r = '0; a_i = '0; wn_r = '0; wn_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || data_out_r !== 16'sd0 || data_out_i !== 16'sd0) begin
      errors++;
      $display("FAIL reset_state got valid=%b (%0d,%0d) expected valid=0 (0,0)",
               valid_o, data_out_r, data_out_i);
    end
    rst = 1'b1;
    idle(2);

    // Impulse
    set_frame(1'b0, 1'b0);
    fxr[0] = 100; fwr[0] = 64; fwi[0] = 0;
    run_frame(1'b0, 16);
    idle(2);

    // Constant input; valid must be high for exactly 32 cycles
    set_frame(1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin fxr[k] = 1000; fxi[k] = -500; end
    v0 = vcnt;
    run_frame(1'b0, 16);
    @(posedge clk); #3;
    checks++;
    if (vcnt - v0 != 32) begin
      errors++;
      $display("FAIL valid_len got=%0d expected=32", vcnt - v0);
    end
    idle(1);

    // Saturation
    set_frame(1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      fxr[k] = 30000;  fxi[k] = -30000;
      fxr[k+16] = -30000; fxi[k+16] = 30000;
    end
    fwr[0] = 64; fwi[0] = 0;
    run_frame(1'b0, 16);
    idle(1);

    // Twiddle and rounding
    set_frame(1'b0, 1'b0);
    fxr[0] = 1000; fwr[0] = 0;  fwi[0] = -64;
    fxr[1] = 1;    fwr[1] = 59; fwi[1] = -25;
    run_frame(1'b0, 16);

    // Back-to-back random frames, WAITING right after SECOND
    for (int f = 0; f < 3; f++) begin
      set_frame(1'b1, 1'b1);
      run_frame(1'b0, 16);
    end
    idle(2);

    // IDLE mid-frame, then a clean frame
    set_frame(1'b1, 1'b1);
    run_frame(1'b0, 5);
    idle(3);
    set_frame(1'b1, 1'b1);
    run_frame(1'b0, 16);

    // Reset mid-frame
    set_frame(1'b1, 1'b1);
    run_frame(1'b0, 6);
    @(negedge clk);
    rst = 1'b0; state = S_IDLE; valid_i = 1'b0;
    @(posedge clk); #3;
    checks++;
    if (valid_o !== 1'b0 || data_out_r !== 16'sd0 || data_out_i !== 16'sd0) begin
      errors++;
      $display("FAIL reset_midframe got valid=%b (%0d,%0d) expected valid=0 (0,0)",
               valid_o, data_out_r, data_out_i);
    end
    @(negedge clk);
    rst = 1'b1;
    // FIRST straight after reset exposes the cleared delay line
    set_frame(1'b0, 1'b1);
    run_frame(1'b1, 16);
    set_frame(1'b1, 1'b1);
    run_frame(1'b0, 16);
    idle(3);

    @(posedge clk); #3;
    checks++;
    if (exp_r.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs got=%0d pending expected=0", exp_r.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
